imem_prog: RTL and testbench

Programmable instruction memory for the single-cycle core: an N-bit × DEPTH word store with a registered fetch port and a byte-serial load port. It replaces the fixed ROM, so a host (UART bridge or testbench) can stream a new program into the core without resynthesis. After reset it zeroes its contents, loads programs on request, and serves instruction fetches with one-cycle latency and an out-of-range flag.

---
 rtl/imem_prog.sv | 167 ++++++++++++++++
 tb/tb_imem_prog.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_prog.sv
// Programmable instruction memory: zeroed after reset, loaded byte-serially,
// fetched through a registered read port with one-cycle latency.
module imem_prog #(
  parameter int unsigned N      = 32,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       prog_en,
  input  logic                       byte_valid,
  input  logic [7:0]                 byte_data,
  output logic                       byte_ready,
  output logic [$clog2(DEPTH+1)-1:0] words_loaded,
  output logic                       mem_full,
  output logic                       busy,
  input  logic                       fetch_req,
  input  logic [ADDR_W-1:0]          fetch_addr,
  output logic                       fetch_valid,
  output logic [N-1:0]               q,
  output logic                       fetch_err
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned WL_W  = $clog2(DEPTH + 1);
  localparam int unsigned LANES = N / 8;
  localparam int unsigned BC_W  = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    S_CLEAR,
    S_RUN,
    S_LOAD
  } state_t;

  logic [N-1:0]    mem [DEPTH];

  state_t          state_q, state_d;
  logic [AW-1:0]   clear_ptr_q, clear_ptr_d;
  logic [WL_W-1:0] wl_d;
  logic [BC_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [N-1:0]    asm_q, asm_d;
  logic [N-1:0]    q_d;
  logic            fetch_err_d, fetch_valid_d;
  logic            mem_full_d, byte_ready_d, busy_d;

  logic            accept_c;
  logic            in_range_c;
  logic [N-1:0]    asm_mrg_c;
  logic            mem_we_c;
  logic [AW-1:0]   mem_waddr_c;
  logic [N-1:0]    mem_wdata_c;

  // Assembly register with the incoming byte dropped into its lane
  always_comb begin
    asm_mrg_c = asm_q;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (byte_cnt_q == BC_W'(i)) asm_mrg_c[i*8 +: 8] = byte_data;
    end
  end

  assign accept_c   = (state_q == S_LOAD) && byte_valid && byte_ready;
  assign in_range_c = ((fetch_addr >> AW) == '0);

  // Next-state, write port and next register values
  always_comb begin
    state_d       = state_q;
    clear_ptr_d   = clear_ptr_q;
    wl_d          = words_loaded;
    byte_cnt_d    = byte_cnt_q;
    asm_d         = asm_q;
    q_d           = q;
    fetch_err_d   = fetch_err;
    fetch_valid_d = 1'b0;
    mem_we_c      = 1'b0;
    mem_waddr_c   = clear_ptr_q;
    mem_wdata_c   = '0;

    case (state_q)
      S_CLEAR: begin
        mem_we_c    = 1'b1;
        clear_ptr_d = clear_ptr_q + AW'(1);
        if (clear_ptr_q == AW'(DEPTH - 1)) state_d = S_RUN;
      end
      S_RUN: begin
        if (fetch_req) begin
          fetch_valid_d = 1'b1;
          if (in_range_c) begin
            q_d         = mem[fetch_addr[AW-1:0]];
            fetch_err_d = 1'b0;
          end else begin
            q_d         = '0;
            fetch_err_d = 1'b1;
          end
        end
        if (prog_en) begin
          state_d    = S_LOAD;
          wl_d       = '0;
          byte_cnt_d = '0;
          asm_d      = '0;
        end
      end
      S_LOAD: begin
        if (accept_c) begin
          if (byte_cnt_q == BC_W'(LANES - 1)) begin
            mem_we_c    = 1'b1;
            mem_waddr_c = words_loaded[AW-1:0];
            mem_wdata_c = asm_mrg_c;
            wl_d        = words_loaded + WL_W'(1);
            byte_cnt_d  = '0;
            asm_d       = '0;
          end else begin
            byte_cnt_d  = byte_cnt_q + BC_W'(1);
            asm_d       = asm_mrg_c;
          end
        end
        // Leaving load mode drops any partially assembled word
        if (!prog_en) begin
          state_d    = S_RUN;
          byte_cnt_d = '0;
          asm_d      = '0;
        end
      end
      default: state_d = S_CLEAR;
    endcase

    mem_full_d   = (wl_d == WL_W'(DEPTH));
    byte_ready_d = (state_d == S_LOAD) && !mem_full_d;
    busy_d       = (state_d != S_RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_CLEAR;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clear_ptr_q  <= '0;
      words_loaded <= '0;
      byte_cnt_q   <= '0;
      asm_q        <= '0;
      q            <= '0;
      fetch_valid  <= 1'b0;
      fetch_err    <= 1'b0;
      byte_ready   <= 1'b0;
      mem_full     <= 1'b0;
      busy         <= 1'b1;
    end else begin
      clear_ptr_q  <= clear_ptr_d;
      words_loaded <= wl_d;
      byte_cnt_q   <= byte_cnt_d;
      asm_q        <= asm_d;
      q            <= q_d;
      fetch_valid  <= fetch_valid_d;
      fetch_err    <= fetch_err_d;
      byte_ready   <= byte_ready_d;
      mem_full     <= mem_full_d;
      busy         <= busy_d;
    end
  end

  // Storage has no reset; CLEAR zeroes it after every reset
  always_ff @(posedge clk) begin
    if (mem_we_c) mem[mem_waddr_c] <= mem_wdata_c;
  end

endmodule

// File: tb/tb_imem_prog.sv
// Directed bench for imem_prog: clear, load, partial/full load, range errors,
// simultaneous fetch/load entry and reset during a load.
module tb_imem_prog;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        prog_en = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        fetch_req = 1'b0;
  logic [9:0]  fetch_addr = 10'd0;
  logic        byte_ready;
  logic [6:0]  words_loaded;
  logic        mem_full;
  logic        busy;
  logic        fetch_valid;
  logic [31:0] q;
  logic        fetch_err;

  int total = 0;
  int bad   = 0;

  imem_prog #(.N(32), .DEPTH(64), .ADDR_W(10)) dut (
    .clk(clk), .reset(reset), .prog_en(prog_en), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .words_loaded(words_loaded),
    .mem_full(mem_full), .busy(busy), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_valid(fetch_valid), .q(q), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] exp_q;
    logic        exp_err;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic wait_clear(output int cycles, output int fv_seen);
    cycles  = 0;
    fv_seen = 0;
    while (busy && cycles < 200) begin
      cycles++;
      @(negedge clk);
      if (fetch_valid) fv_seen++;
    end
  endtask

  task automatic fetch(input logic [9:0] a, output logic [31:0] rq,
                       output logic re, output logic rv);
    fetch_req  = 1'b1;
    fetch_addr = a;
    @(negedge clk);
    rq = q;
    re = fetch_err;
    rv = fetch_valid;
    fetch_req = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    while (!byte_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!byte_ready) chk("byte_ready_timeout", 32'(byte_ready), 32'd1);
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clk);
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    chk({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
    chk({tag, "_mem_full"}, 32'(mem_full), 32'd0);
    chk({tag, "_fetch_valid"}, 32'(fetch_valid), 32'd0);
    chk({tag, "_q"}, q, 32'd0);
    chk({tag, "_fetch_err"}, 32'(fetch_err), 32'd0);
  endtask

  initial begin
    logic [31:0] rq;
    logic        re, rv;
    int          cyc, fvs, errs;
    logic [7:0]  prog [8];
    logic [31:0] w;

    prog[0] = 8'h37; prog[1] = 8'h00; prog[2] = 8'h01; prog[3] = 8'hCB;
    prog[4] = 8'hE0; prog[5] = 8'h03; prog[6] = 8'h04; prog[7] = 8'h8B;

    vecs[0] = '{10'd0,    32'hCB010037, 1'b0};
    vecs[1] = '{10'd1,    32'h8B0403E0, 1'b0};
    vecs[2] = '{10'd2,    32'h00000000, 1'b0};
    vecs[3] = '{10'd63,   32'h00000000, 1'b0};
    vecs[4] = '{10'd64,   32'h00000000, 1'b1};
    vecs[5] = '{10'd1023, 32'h00000000, 1'b1};
    vecs[6] = '{10'd0,    32'hCB010037, 1'b0};

    // Reset and clear, with a fetch held during CLEAR
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    fetch_req = 1'b1;
    fetch_addr = 10'd5;
    reset = 1'b0;
    wait_clear(cyc, fvs);
    fetch_req = 1'b0;
    chk("clear_cycles", 32'(cyc), 32'd64);
    chk("fv_during_clear", 32'(fvs), 32'd0);

    errs = 0;
    for (int a = 0; a < 64; a++) begin
      fetch(10'(a), rq, re, rv);
      if (rq !== 32'd0 || re !== 1'b0 || rv !== 1'b1) errs++;
    end
    chk("cleared_words_bad", 32'(errs), 32'd0);

    // Two words plus a discarded 3-byte partial, fetch held during LOAD
    prog_en = 1'b1;
    @(negedge clk);
    chk("load_entry_ready", 32'(byte_ready), 32'd1);
    fetch_req = 1'b1;
    fetch_addr = 10'd0;
    for (int i = 0; i < 8; i++) send_byte(prog[i], 0);
    chk("fv_during_load", 32'(fetch_valid), 32'd0);
    fetch_req = 1'b0;
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    send_byte(8'hCC, 0);
    prog_en = 1'b0;
    @(negedge clk);
    chk("partial_words_loaded", 32'(words_loaded), 32'd2);
    chk("partial_busy", 32'(busy), 32'd0);
    chk("partial_ready", 32'(byte_ready), 32'd0);

    // Table of fetches including out-of-range addresses
    for (int i = 0; i < 7; i++) begin
      fetch(vecs[i].addr, rq, re, rv);
      chk($sformatf("vec%0d_q", i), rq, vecs[i].exp_q);
      chk($sformatf("vec%0d_err", i), 32'(re), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_valid", i), 32'(rv), 32'd1);
    end
    @(negedge clk);
    chk("idle_fv", 32'(fetch_valid), 32'd0);
    chk("idle_q_hold", q, 32'hCB010037);

    // Fetch on the same edge as load entry, then gapped streaming
    prog_en = 1'b1;
    fetch_req = 1'b1;
    fetch_addr = 10'd1;
    @(negedge clk);
    chk("same_edge_fv", 32'(fetch_valid), 32'd1);
    chk("same_edge_q", q, 32'h8B0403E0);
    chk("same_edge_busy", 32'(busy), 32'd1);
    chk("same_edge_wl", 32'(words_loaded), 32'd0);
    @(negedge clk);
    chk("load_fv_low", 32'(fetch_valid), 32'd0);
    fetch_req = 1'b0;
    for (int i = 0; i < 8; i++) send_byte(8'(8'h11 * (i + 1)), 2);
    prog_en = 1'b0;
    @(negedge clk);
    chk("gap_wl", 32'(words_loaded), 32'd2);
    fetch(10'd0, rq, re, rv);
    chk("gap_w0", rq, 32'h44332211);
    fetch(10'd1, rq, re, rv);
    chk("gap_w1", rq, 32'h88776655);
    fetch(10'd2, rq, re, rv);
    chk("gap_w2", rq, 32'h00000000);

    // Full load of 256 bytes, then 4 refused bytes
    prog_en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      send_byte(8'(i), 0);
      if (i == 254) chk("ready_before_last", 32'(byte_ready), 32'd1);
    end
    chk("full_flag", 32'(mem_full), 32'd1);
    chk("full_ready", 32'(byte_ready), 32'd0);
    for (int k = 0; k < 4; k++) begin
      byte_valid = 1'b1;
      byte_data = 8'hEE;
      @(negedge clk);
    end
    byte_valid = 1'b0;
    chk("full_ready_after_extra", 32'(byte_ready), 32'd0);
    chk("full_wl", 32'(words_loaded), 32'd64);
    prog_en = 1'b0;
    @(negedge clk);
    chk("full_hold_run", 32'(mem_full), 32'd1);
    chk("full_wl_run", 32'(words_loaded), 32'd64);
    fetch(10'd63, rq, re, rv);
    chk("full_w63", rq, 32'hFFFEFDFC);
    fetch(10'd62, rq, re, rv);
    chk("full_w62", rq, 32'hFBFAF9F8);
    fetch(10'd0, rq, re, rv);
    chk("full_w0", rq, 32'h03020100);

    // Reset after five words of a new load
    prog_en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 20; i++) send_byte(8'hA0 + 8'(i), 0);
    chk("midload_wl", 32'(words_loaded), 32'd5);
    chk("midload_q_before", q, 32'h03020100);
    #2 reset = 1'b1;
    #1 check_reset_vals("midrst");
    prog_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    wait_clear(cyc, fvs);
    chk("midrst_clear_cycles", 32'(cyc), 32'd64);
    for (int a = 0; a < 5; a++) begin
      fetch(10'(a), rq, re, rv);
      w = rq;
      chk($sformatf("midrst_w%0d", a), w, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
